// File: rtl/encrypt_out_packer_if.sv
// Bundles the byte-in, word-out handshake and status signals of encrypt_out_packer.
// slave = packer view (consumes bytes, drives words); master = environment view.
interface encrypt_out_packer_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          v;
    logic [7:0]    din;
    logic          flush;
    logic          m_ready;
    logic          m_valid;
    logic [31:0]   m_data;
    logic [2:0]    m_bytes;
    logic          almost_full;
    logic [LW-1:0] level;
    logic          overflow;

    modport slave (
        input  v, din, flush, m_ready,
        output m_valid, m_data, m_bytes, almost_full, level, overflow
    );

    modport master (
        output v, din, flush, m_ready,
        input  m_valid, m_data, m_bytes, almost_full, level, overflow
    );
endinterface

// File: rtl/encrypt_out_packer.sv
// Packs the encrypted byte stream little-endian into 32-bit words and buffers them in a
// show-ahead word FIFO; the byte source cannot stall, so full-FIFO words are dropped and flagged.
module encrypt_out_packer #(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    encrypt_out_packer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] L_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] L_AFULL = LW'(DEPTH - AFULL_MARGIN);

    logic [31:0]   r_pk_data;
    logic [1:0]    r_pk_cnt;
    logic [31:0]   r_mem_data  [DEPTH];
    logic [2:0]    r_mem_bytes [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_afull;
    logic          r_overflow;

    logic [31:0]   w_pk_data;
    logic [2:0]    w_pk_cnt;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_valid;
    logic [LW-1:0] w_level_next;

    // Pack view including a same-cycle byte, so flush and a 4th byte merge into one push.
    always_comb begin
        w_pk_data = r_pk_data;
        w_pk_cnt  = {1'b0, r_pk_cnt};
        if (bus.v) begin
            case (r_pk_cnt)
                2'd0:    w_pk_data[7:0]   = bus.din;
                2'd1:    w_pk_data[15:8]  = bus.din;
                2'd2:    w_pk_data[23:16] = bus.din;
                default: w_pk_data[31:24] = bus.din;
            endcase
            w_pk_cnt = {1'b0, r_pk_cnt} + 3'd1;
        end
    end

    assign w_valid    = (r_level != '0);
    assign w_pop      = w_valid && bus.m_ready;
    assign w_push_req = (w_pk_cnt == 3'd4) || (bus.flush && (w_pk_cnt != 3'd0));
    assign w_push_ok  = w_push_req && ((r_level != L_FULL) || w_pop);

    always_comb begin
        w_level_next = r_level;
        if (w_push_ok && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_push_ok && w_pop) begin
            w_level_next = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pk_data  <= '0;
            r_pk_cnt   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_req) begin
                r_pk_data <= '0;
                r_pk_cnt  <= '0;
            end else begin
                r_pk_data <= w_pk_data;
                r_pk_cnt  <= w_pk_cnt[1:0];
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            r_level <= w_level_next;
            r_afull <= (w_level_next >= L_AFULL);
        end
    end

    // Storage needs no reset: every read is masked by level.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem_data[r_wr_ptr]  <= w_pk_data;
            r_mem_bytes[r_wr_ptr] <= w_pk_cnt;
        end
    end

    assign bus.m_valid     = w_valid;
    assign bus.m_data      = w_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign bus.m_bytes     = w_valid ? r_mem_bytes[r_rd_ptr] : '0;
    assign bus.almost_full = r_afull;
    assign bus.level       = r_level;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_encrypt_out_packer.sv
// Directed bench for encrypt_out_packer: stimulus queues expected words, a negedge monitor
// pops and compares them on every accepted output word.
module tb_encrypt_out_packer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [34:0] exp_q [$];
    logic [34:0] e;

    always #5 clk = ~clk;

    encrypt_out_packer_if #(.DEPTH(DEPTH)) bus ();

    encrypt_out_packer #(.DEPTH(DEPTH), .AFULL_MARGIN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic ifl);
        bus.v     = iv;
        bus.din   = id;
        bus.flush = ifl;
        @(posedge clk);
        #1;
        bus.v     = 1'b0;
        bus.din   = 8'h00;
        bus.flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h bytes %0d expected none", bus.m_data, bus.m_bytes);
            end else begin
                e = exp_q.pop_front();
                if ({bus.m_bytes, bus.m_data} !== e) begin
                    errors++;
                    $display("FAIL word: got %h bytes %0d expected %h bytes %0d",
                             bus.m_data, bus.m_bytes, e[31:0], e[34:32]);
                end
            end
        end
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        int          words;
        bus.v = 1'b0; bus.din = 8'h00; bus.flush = 1'b0; bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_afull", 32'(bus.almost_full), 32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        chk("rst_bytes", 32'(bus.m_bytes), 32'd0);
        rst = 1'b0;

        // 1) two back-to-back full words
        bus.m_ready = 1'b1;
        exp_q.push_back({3'd4, 32'h04030201});
        exp_q.push_back({3'd4, 32'h08070605});
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 4) begin
                chk("t1_lat_valid", 32'(bus.m_valid), 32'd1);
                chk("t1_lat_data",  bus.m_data, 32'h04030201);
            end
        end
        chk("t1_lat_valid2", 32'(bus.m_valid), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_level", 32'(bus.level), 32'd0);

        // 2) partial flush, then flush with nothing packed
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        step(1'b1, 8'hCC, 1'b0);
        exp_q.push_back({3'd3, 32'h00CCBBAA});
        step(1'b0, 8'h00, 1'b1);
        chk("t2_bytes", 32'(bus.m_bytes), 32'd3);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t2_empty_flush", 32'(bus.m_valid), 32'd0);

        // 3) fill the FIFO with the consumer stalled
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            b = 8'(8'h10 + i);
            if ((i % 4) == 3) begin
                w = {b, 8'(b - 8'd1), 8'(b - 8'd2), 8'(b - 8'd3)};
                exp_q.push_back({3'd4, w});
            end
            step(1'b1, b, 1'b0);
            if ((i % 4) == 3) begin
                words = i / 4 + 1;
                chk("t3_level", 32'(bus.level), 32'(words));
                chk("t3_afull", 32'(bus.almost_full), (words >= 6) ? 32'd1 : 32'd0);
            end
        end
        chk("t3_valid", 32'(bus.m_valid), 32'd1);
        chk("t3_ovf0",  32'(bus.overflow), 32'd0);

        // 4) full FIFO, 4th byte coincides with a pop
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'hF1, 1'b0);
        step(1'b1, 8'hF2, 1'b0);
        exp_q.push_back({3'd4, 32'hF3F2F1F0});
        bus.m_ready = 1'b1;
        step(1'b1, 8'hF3, 1'b0);
        bus.m_ready = 1'b0;
        chk("t4_level", 32'(bus.level), 32'(DEPTH));
        chk("t4_ovf0",  32'(bus.overflow), 32'd0);

        // 3b) one more word into a full FIFO is dropped
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
        chk("t3_ovf1",   32'(bus.overflow), 32'd1);
        chk("t3_level2", 32'(bus.level), 32'(DEPTH));
        chk("t3_afull2", 32'(bus.almost_full), 32'd1);

        bus.m_ready = 1'b1;
        for (int n = 0; n < 40 && bus.level != '0; n++) step(1'b0, 8'h00, 1'b0);
        chk("t3_drained", 32'(bus.level), 32'd0);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 5) v+flush on the 3rd byte, then v+flush on the 4th byte
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        exp_q.push_back({3'd3, 32'h00332211});
        step(1'b1, 8'h33, 1'b1);
        chk("t5_bytes3", 32'(bus.m_bytes), 32'd3);
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        exp_q.push_back({3'd4, 32'h77665544});
        step(1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_level", 32'(bus.level), 32'd0);

        // 6) reset mid-word with FIFO half full
        bus.m_ready = 1'b0;
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("t6_level_pre", 32'(bus.level), 32'd4);
        rst = 1'b1;
        step(1'b1, 8'hFF, 1'b1);
        rst = 1'b0;
        chk("t6_level", 32'(bus.level), 32'd0);
        chk("t6_valid", 32'(bus.m_valid), 32'd0);
        chk("t6_ovf",   32'(bus.overflow), 32'd0);
        chk("t6_afull", 32'(bus.almost_full), 32'd0);
        bus.m_ready = 1'b1;
        exp_q.push_back({3'd4, 32'hA4A3A2A1});
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        step(1'b1, 8'hA4, 1'b0);
        chk("t6_fresh", bus.m_data, 32'hA4A3A2A1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("end_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_valid",   32'(bus.m_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
